// File: rtl/ram_arb_pkg.sv
// Shared encodings and default sizing for the RAM arbiter slice.
// State encoding, requester ids and default widths live here so the
// top and the round-robin picker agree on them.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;  // instruction-fetch requester
  localparam logic PORT_LS = 1'b1;  // load/store requester

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 128;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Purpose: combinational 2-way round-robin pick; the caller owns last_grant.
// Latency: zero (pure combinational).
// Backpressure: none; the caller decides when a pick is consumed.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_grant_valid,
  output logic o_grant_id
);

  // Under contention the port that did not win last time goes next.
  always_comb begin
    o_grant_valid = i_req0 | i_req1;
    o_grant_id    = PORT_IF;
    if (i_req0 && i_req1) begin
      o_grant_id = ~i_last_grant;
    end else if (i_req1) begin
      o_grant_id = PORT_LS;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Purpose: arbitrates two requesters onto a single-port negedge RAM, returns read data.
// Latency: grant at posedge T, ack registered at posedge T+1 and held one cycle.
// Backpressure: requesters hold req/fields until ack; one access per 3 cycles.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_last_grant;
  logic                r_gnt;
  logic                r_is_read;
  logic                r_err_pend;
  logic                r_ack0;
  logic                r_ack1;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_ram_wr;
  logic                r_ram_rd;

  logic                w_gnt_vld;
  logic                w_gnt_id;
  logic                w_we_g;
  logic [ADDR_W-1:0]   w_addr_g;
  logic [DATA_W-1:0]   w_wdata_g;
  logic                w_addr_ok;

  rr_arb2 u_rr (
    .i_req0        (req0),
    .i_req1        (req1),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_gnt_vld),
    .o_grant_id    (w_gnt_id)
  );

  // Steer the winner's request fields and check its address range.
  always_comb begin
    w_we_g    = (w_gnt_id == PORT_LS) ? we1    : we0;
    w_addr_g  = (w_gnt_id == PORT_LS) ? addr1  : addr0;
    w_wdata_g = (w_gnt_id == PORT_LS) ? wdata1 : wdata0;
    w_addr_ok = ({1'b0, w_addr_g} < LP_DEPTH);
  end

  // Next-state: reqs only matter in IDLE; ACCESS and DONE last one cycle each.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_gnt_vld) w_next_state = ACCESS;
      ACCESS:  w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Datapath: launch the RAM command on grant, capture read data after the
  // RAM's negedge access, then pulse ack/err for exactly the DONE cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_last_grant <= PORT_LS;
      r_gnt        <= PORT_IF;
      r_is_read    <= 1'b0;
      r_err_pend   <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err        <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_ram_wr     <= 1'b0;
      r_ram_rd     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_gnt        <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            r_ram_addr   <= w_addr_g;
            r_ram_wdata  <= w_wdata_g;
            r_is_read    <= ~w_we_g;
            r_err_pend   <= ~w_addr_ok;
            // An out-of-range access never touches the RAM.
            r_ram_wr     <= w_we_g & w_addr_ok;
            r_ram_rd     <= ~w_we_g & w_addr_ok;
          end
        end
        ACCESS: begin
          r_ram_wr <= 1'b0;
          r_ram_rd <= 1'b0;
          r_err    <= r_err_pend;
          if (r_gnt == PORT_LS) begin
            r_ack1 <= 1'b1;
            if (r_is_read) r_rdata1 <= r_err_pend ? '0 : ram_rdata;
          end else begin
            r_ack0 <= 1'b1;
            if (r_is_read) r_rdata0 <= r_err_pend ? '0 : ram_rdata;
          end
        end
        DONE: begin
          r_ack0     <= 1'b0;
          r_ack1     <= 1'b0;
          r_err      <= 1'b0;
          r_err_pend <= 1'b0;
        end
        default: begin
          r_ram_wr <= 1'b0;
          r_ram_rd <= 1'b0;
        end
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign err       = r_err;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_wr    = r_ram_wr;
  assign ram_rd    = r_ram_rd;
  assign busy      = (r_state != IDLE);

endmodule
